bw_mac_accumulator: RTL and testbench

- Downstream consumer of the 5-bit signed Baugh-Wooley product stage.
- Takes signed products over a valid/ready handshake and sums a variable-length run of terms in a sign-extended accumulator.
- Emits each dot-product result with a term count and a sticky overflow flag over a second valid/ready handshake.
- Forms the registered half of the team's MAC datapath; the multiplier in front of it stays purely combinational.

---
 rtl/bw_mac_accumulator_if.sv | 28 ++
 rtl/bw_mac_accumulator.sv | 145 ++++++++++++++
 tb/tb_bw_mac_accumulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bw_mac_accumulator_if.sv
// Bus bundle for the MAC accumulator: the term-input handshake and the
// result-output handshake. The accumulator takes the slave side; the
// producer/consumer environment takes the master side.
interface bw_mac_accumulator_if #(
  parameter int N     = 5,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic signed [2*N-1:0]   prod_in;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output prod_in, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_ovf, out_valid
  );

  modport slave (
    input  prod_in, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/bw_mac_accumulator.sv
// bw_mac_accumulator: registered dot-product accumulator that sits behind the
// combinational Baugh-Wooley multiplier. Sums a run of signed products
// (terminated by in_last) and presents the result with a term count and a
// sticky overflow flag.
// Optional macro BW_MAC_SAT_EN: when defined the accumulator clamps on
// overflow instead of wrapping; ports and timing are identical either way.
module bw_mac_accumulator #(
  parameter int N     = 5,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bw_mac_accumulator_if.slave   mac
);

  localparam int PW = 2 * N;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic                 r_first;

  logic [ACC_W-1:0]     r_out_data;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_ovf;

  logic                 w_out_valid;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_accept_last;

  logic [ACC_W-1:0]     w_prod_sext;
  logic [ACC_W-1:0]     w_addend;
  logic [ACC_W:0]       w_sum;
  logic                 w_ovf_now;
  logic [ACC_W-1:0]     w_acc_res;
  logic [CNT_W-1:0]     w_cnt_res;
  logic                 w_ovf_res;

  // Sign-extend the product to the accumulator width, bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_prod_bits
      assign w_prod_sext[gi] = mac.prod_in[gi];
    end
    for (gi = PW; gi < ACC_W; gi++) begin : g_sign_bits
      assign w_prod_sext[gi] = mac.prod_in[PW-1];
    end
  endgenerate

  // The first term of a run starts from zero rather than the stale accumulator.
  assign w_addend = r_first ? '0 : r_acc;

  // One extra bit holds the true sign of the result. For sign-extended
  // operands, bits ACC_W and ACC_W-1 differ exactly when two same-signed
  // operands produced an opposite-signed ACC_W-bit result.
  assign w_sum     = {w_addend[ACC_W-1], w_addend} + {w_prod_sext[ACC_W-1], w_prod_sext};
  assign w_ovf_now = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef BW_MAC_SAT_EN
  // Clamp toward the operands' sign (carried in the extra bit) on overflow.
  assign w_acc_res = !w_ovf_now ? w_sum[ACC_W-1:0] :
                     (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}});
`else
  // Plain modulo-2^ACC_W wrap; the overflow flag records that it happened.
  assign w_acc_res = w_sum[ACC_W-1:0];
`endif

  // Term counter restarts at one on a new run and sticks at all-ones.
  assign w_cnt_res = r_first ? CNT_W'(1) :
                     ((r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1));
  assign w_ovf_res = (r_first ? 1'b0 : r_ovf) | w_ovf_now;

  // Handshake decode and ACCUM/HOLD next-state logic.
  always_comb begin
    w_state_next  = r_state;
    w_out_valid   = (r_state == ST_HOLD);
    w_in_ready    = !w_out_valid || mac.out_ready;
    w_accept      = mac.in_valid && w_in_ready;
    w_accept_last = w_accept && mac.in_last;
    case (r_state)
      ST_ACCUM: if (w_accept_last) w_state_next = ST_HOLD;
      ST_HOLD:  if (!w_accept_last && mac.out_ready) w_state_next = ST_ACCUM;
      default:  w_state_next = ST_ACCUM;
    endcase
  end

  // State register for the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  // Running accumulator: advance on every accepted term, clear after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_first <= 1'b1;
    end else if (w_accept) begin
      if (mac.in_last) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_first <= 1'b1;
      end else begin
        r_acc   <= w_acc_res;
        r_cnt   <= w_cnt_res;
        r_ovf   <= w_ovf_res;
        r_first <= 1'b0;
      end
    end
  end

  // Result registers: load only when a last term is accepted, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept_last) begin
      r_out_data  <= w_acc_res;
      r_out_count <= w_cnt_res;
      r_out_ovf   <= w_ovf_res;
    end
  end

  assign mac.in_ready  = w_in_ready;
  assign mac.out_valid = w_out_valid;
  assign mac.out_data  = r_out_data;
  assign mac.out_count = r_out_count;
  assign mac.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// Directed bench for bw_mac_accumulator. Two instances receive identical
// stimulus: one at the default 16-bit accumulator width and one at 12 bits so
// the overflow behaviour is reachable. Expectations for the 12-bit instance
// follow BW_MAC_SAT_EN when the bench is built with it.
module tb_bw_mac_accumulator;

  localparam int N  = 5;
  localparam int PW = 2 * N;
`ifdef BW_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bw_mac_accumulator_if #(.N(N), .ACC_W(16), .CNT_W(8)) if16 ();
  bw_mac_accumulator_if #(.N(N), .ACC_W(12), .CNT_W(8)) if12 ();

  bw_mac_accumulator #(.N(N), .ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .mac (if16.slave)
  );

  bw_mac_accumulator #(.N(N), .ACC_W(12), .CNT_W(8)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .mac (if12.slave)
  );

  task automatic drive(input int p, input logic v, input logic l, input logic r);
    if16.prod_in   = p[PW-1:0];
    if16.in_valid  = v;
    if16.in_last   = l;
    if16.out_ready = r;
    if12.prod_in   = p[PW-1:0];
    if12.in_valid  = v;
    if12.in_last   = l;
    if12.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Check the full result view of both instances.
  task automatic chk_res(input string tag, input int valid, input int cnt,
                         input int d16, input int o16, input int d12, input int o12);
    chk({tag, "/valid16"}, {31'b0, if16.out_valid}, valid);
    chk({tag, "/valid12"}, {31'b0, if12.out_valid}, valid);
    chk({tag, "/data16"},  $signed(if16.out_data), d16);
    chk({tag, "/data12"},  $signed(if12.out_data), d12);
    chk({tag, "/count16"}, {24'b0, if16.out_count}, cnt);
    chk({tag, "/count12"}, {24'b0, if12.out_count}, cnt);
    chk({tag, "/ovf16"},   {31'b0, if16.out_ovf}, o16);
    chk({tag, "/ovf12"},   {31'b0, if12.out_ovf}, o12);
  endtask

  task automatic chk_valid(input string tag, input int valid);
    chk({tag, "/valid16"}, {31'b0, if16.out_valid}, valid);
    chk({tag, "/valid12"}, {31'b0, if12.out_valid}, valid);
  endtask

  task automatic chk_ready(input string tag, input int rdy);
    chk({tag, "/ready16"}, {31'b0, if16.in_ready}, rdy);
    chk({tag, "/ready12"}, {31'b0, if12.in_ready}, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    chk_res("reset", 0, 0, 0, 0, 0, 0);
    chk_ready("reset", 1);
    rst = 1'b0;
    tick();

    // Reset mid-run: three terms of 10, then asynchronous reset, then 7 alone.
    drive(10, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_res("midrst", 0, 0, 0, 0, 0, 0);
    drive(7, 1'b1, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("single7", 1, 1, 7, 0, 7, 0);
    tick();
    chk_valid("single7_drain", 0);

    // Basic run with an idle cycle carrying a stray in_last (must be ignored).
    drive(256, 1'b1, 1'b0, 1'b1); tick();
    drive(0, 1'b0, 1'b1, 1'b1);   tick();
    chk_valid("idle_last", 0);
    drive(-240, 1'b1, 1'b0, 1'b1); tick();
    drive(100, 1'b1, 1'b0, 1'b1);  tick();
    drive(5, 1'b1, 1'b1, 1'b1);    tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("basic", 1, 4, 121, 0, 121, 0);
    tick();
    chk_valid("basic_pulse", 0);

    // Backpressure: result of 30 held while out_ready is low.
    drive(10, 1'b1, 1'b0, 1'b0); tick(); tick();
    drive(10, 1'b1, 1'b1, 1'b0); tick();
    drive(4, 1'b1, 1'b0, 1'b0);
    #1;
    chk_ready("bp_stall", 0);
    chk_res("bp_hold1", 1, 3, 30, 0, 30, 0);
    tick();
    chk_res("bp_hold2", 1, 3, 30, 0, 30, 0);
    drive(4, 1'b1, 1'b0, 1'b1);
    #1;
    chk_ready("bp_release", 1);
    tick();
    chk_valid("bp_drained", 0);
    drive(1, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("bp_next", 1, 2, 5, 0, 5, 0);
    tick();

    // Back-to-back two-term runs, no input bubble.
    drive(1, 1'b1, 1'b0, 1'b1); tick();
    drive(1, 1'b1, 1'b1, 1'b1); tick();
    chk_res("b2b_first", 1, 2, 2, 0, 2, 0);
    drive(2, 1'b1, 1'b0, 1'b1); tick();
    chk_valid("b2b_gap", 0);
    drive(2, 1'b1, 1'b1, 1'b1); tick();
    chk_res("b2b_second", 1, 2, 4, 0, 4, 0);

    // Single-term runs each cycle: out_valid stays high with a fresh result.
    drive(3, 1'b1, 1'b1, 1'b1); tick();
    chk_res("single3", 1, 1, 3, 0, 3, 0);
    drive(-6, 1'b1, 1'b1, 1'b1); tick();
    chk_res("single_m6", 1, 1, -6, 0, -6, 0);
    drive(0, 1'b0, 1'b0, 1'b1); tick();
    chk_valid("single_drain", 0);

    // Positive overflow: eight terms of 256.
    for (int i = 0; i < 7; i++) begin
      drive(256, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(256, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("ovf_pos", 1, 8, 2048, 0, SAT ? 2047 : -2048, 1);
    tick();

    // Negative overflow: nine terms of -240.
    for (int i = 0; i < 8; i++) begin
      drive(-240, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(-240, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("ovf_neg", 1, 9, -2160, 0, SAT ? -2048 : 1936, 1);
    tick();

    // Sticky flag: overflow mid-run, run continues from wrapped/clamped value.
    for (int i = 0; i < 8; i++) begin
      drive(256, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(1, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("ovf_sticky", 1, 9, 2049, 0, SAT ? 2047 : -2047, 1);
    tick();

    // Flag clears for the next clean run.
    drive(-1, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("ovf_cleared", 1, 1, -1, 0, -1, 0);
    tick();

    // Counter saturation: 300 terms in one run report 255.
    for (int i = 0; i < 299; i++) begin
      drive(0, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(0, 1'b1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk_res("cnt_sat", 1, 255, 0, 0, 0, 0);
    tick();
    chk_valid("final_idle", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
